mac_rx_arb: RTL and testbench

MAC_RX_ARB -- requirements
Module: mac_rx_arb

---
 rtl/rv_p4_pkg.sv | 21 ++
 rtl/mac_rx_if.sv | 21 ++
 rtl/mac_rx_arb_rr_arbiter.sv | 40 ++++
 rtl/mac_rx_arb.sv | 177 +++++++++++++++++
 tb/tb_mac_rx_arb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_p4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | rv_p4_pkg : shared widths and arbiter state type for the MAC RX path
// | rev 1.0
// +----------------------------------------------------------------------------
package rv_p4_pkg;

    localparam int NUM_PORTS_DEF = 32;
    localparam int PORT_W        = 5;
    localparam int CELL_W        = 512;
    localparam int LEN_W         = 7;
    localparam int FRAME_CNT_W   = 32;
    localparam int ERR_CNT_W     = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage : rv_p4_pkg
`default_nettype wire

// File: rtl/mac_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mac_rx_if : cell stream from the RX arbiter towards the parser
// | rev 1.0
// +----------------------------------------------------------------------------
interface mac_rx_if;
    import rv_p4_pkg::*;

    logic                valid;
    logic                ready;
    logic [CELL_W-1:0]   data;
    logic                sof;
    logic                eof;
    logic [LEN_W-1:0]    eop_len;
    logic [PORT_W-1:0]   port;

    modport src (output valid, data, sof, eof, eop_len, port, input ready);
    modport dst (input valid, data, sof, eof, eop_len, port, output ready);

endinterface : mac_rx_if
`default_nettype wire

// File: rtl/mac_rx_arb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | rr_arbiter : combinational round-robin grant (rotate, then priority-encode)
// | rev 1.0
// +----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 32,
    parameter int PTR_W = 5
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] base,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     w_rot;
    logic [PTR_W-1:0] w_ofs;
    logic [PTR_W:0]   w_sum;

    // Bit 0 of the rotated vector is the request of port 'base'.
    assign w_rot = N'({req, req} >> base);
    assign any   = |req;

    always_comb begin
        w_ofs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ofs = PTR_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, base} + {1'b0, w_ofs};
    assign idx   = (w_sum >= (PTR_W + 1)'(N)) ? PTR_W'(w_sum - (PTR_W + 1)'(N))
                                               : w_sum[PTR_W-1:0];
    assign gnt   = any ? (N'(1) << idx) : '0;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mac_rx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mac_rx_arb : frame-atomic round-robin merge of MAC RX ports onto one stream
// | rev 1.0
// +----------------------------------------------------------------------------
module mac_rx_arb
    import rv_p4_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF
) (
    input  logic                             clk_dp,
    input  logic                             rst_dp_n,
    input  logic [NUM_PORTS-1:0]             in_valid,
    output logic [NUM_PORTS-1:0]             in_ready,
    input  logic [NUM_PORTS-1:0][CELL_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]             in_sof,
    input  logic [NUM_PORTS-1:0]             in_eof,
    input  logic [NUM_PORTS-1:0][LEN_W-1:0]  in_eop_len,
    mac_rx_if.src                            rx,
    output logic [FRAME_CNT_W-1:0]           frame_cnt,
    output logic [ERR_CNT_W-1:0]             orphan_cnt,
    output logic [ERR_CNT_W-1:0]             sof_err_cnt
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [PORT_W-1:0]      r_rr_ptr;
    logic [PORT_W-1:0]      w_rr_ptr_nxt;
    logic [PORT_W-1:0]      r_lock_port;
    logic [PORT_W-1:0]      w_lock_port_nxt;
    logic                   r_ready_en;

    logic                   r_valid;
    logic [CELL_W-1:0]      r_data;
    logic                   r_sof;
    logic                   r_eof;
    logic [LEN_W-1:0]       r_len;
    logic [PORT_W-1:0]      r_port;

    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [ERR_CNT_W-1:0]   r_orphan_cnt;
    logic [ERR_CNT_W-1:0]   r_sof_err_cnt;

    logic [NUM_PORTS-1:0]   w_req_sof;
    logic [NUM_PORTS-1:0]   w_orphan;
    logic [NUM_PORTS-1:0]   w_gnt;
    logic [PORT_W-1:0]      w_arb_idx;
    logic                   w_arb_any;
    logic                   w_out_free;

    logic [NUM_PORTS-1:0]   w_ready;
    logic                   w_load;
    logic [PORT_W-1:0]      w_sel;
    logic                   w_sof_err;
    logic                   w_orphan_hit;

    assign w_req_sof  = in_valid & in_sof;
    assign w_orphan   = in_valid & ~in_sof;
    assign w_out_free = ~r_valid | rx.ready;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .PTR_W (PORT_W)
    ) u_rr_arbiter (
        .req  (w_req_sof),
        .base (r_rr_ptr),
        .gnt  (w_gnt),
        .idx  (w_arb_idx),
        .any  (w_arb_any)
    );

    // Nothing is accepted until one clock after reset release.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_lock_port_nxt = r_lock_port;
        w_ready         = '0;
        w_load          = 1'b0;
        w_sel           = r_lock_port;
        w_sof_err       = 1'b0;
        w_orphan_hit    = 1'b0;
        if (r_ready_en) begin
            unique case (r_state)
                ARB_IDLE: begin
                    w_sel        = w_arb_idx;
                    w_orphan_hit = |w_orphan;
                    // Orphans drain regardless of output backpressure.
                    w_ready      = w_orphan | (w_out_free ? w_gnt : '0);
                    if (w_arb_any && w_out_free) begin
                        w_load          = 1'b1;
                        w_lock_port_nxt = w_arb_idx;
                        w_rr_ptr_nxt    = (w_arb_idx == PORT_W'(NUM_PORTS - 1)) ? '0
                                                                               : w_arb_idx + 1'b1;
                        if (!in_eof[w_arb_idx]) begin
                            w_state_nxt = ARB_LOCK;
                        end
                    end
                end
                ARB_LOCK: begin
                    w_ready[r_lock_port] = w_out_free;
                    if (w_out_free && in_valid[r_lock_port]) begin
                        w_load    = 1'b1;
                        w_sof_err = in_sof[r_lock_port];
                        if (in_eof[r_lock_port]) begin
                            w_state_nxt = ARB_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_lock_port <= '0;
            r_ready_en  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lock_port <= w_lock_port_nxt;
            r_ready_en  <= 1'b1;
        end
    end

    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_sof         <= 1'b0;
            r_eof         <= 1'b0;
            r_len         <= '0;
            r_port        <= '0;
            r_frame_cnt   <= '0;
            r_orphan_cnt  <= '0;
            r_sof_err_cnt <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= in_data[w_sel];
                // A repeated SOF inside a locked frame is passed on as a body cell.
                r_sof   <= in_sof[w_sel] & (r_state == ARB_IDLE);
                r_eof   <= in_eof[w_sel];
                r_len   <= in_eop_len[w_sel];
                r_port  <= w_sel;
            end else if (rx.ready) begin
                r_valid <= 1'b0;
            end
            if (w_load && in_eof[w_sel] && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_orphan_hit && (r_orphan_cnt != '1)) begin
                r_orphan_cnt <= r_orphan_cnt + 1'b1;
            end
            if (w_sof_err && (r_sof_err_cnt != '1)) begin
                r_sof_err_cnt <= r_sof_err_cnt + 1'b1;
            end
        end
    end

    assign in_ready    = w_ready;
    assign rx.valid    = r_valid;
    assign rx.data     = r_data;
    assign rx.sof      = r_sof;
    assign rx.eof      = r_eof;
    assign rx.eop_len  = r_len;
    assign rx.port     = r_port;
    assign frame_cnt   = r_frame_cnt;
    assign orphan_cnt  = r_orphan_cnt;
    assign sof_err_cnt = r_sof_err_cnt;

endmodule : mac_rx_arb
`default_nettype wire

// File: tb/tb_mac_rx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_mac_rx_arb : directed vector table, random traffic vs. cycle model
// | rev 1.0
// +----------------------------------------------------------------------------
module tb_mac_rx_arb;

    localparam int NP = 32;

    typedef struct {
        logic [31:0] v;
        logic [31:0] s;
        logic [31:0] e;
        bit          rdy;
        logic [31:0] xr;
        bit          xv;
        int          xp;
        bit          xs;
        bit          xe;
    } vec_t;

    logic                      clk_dp = 1'b0;
    logic                      rst_dp_n = 1'b0;
    logic [NP-1:0]             in_valid;
    logic [NP-1:0]             in_ready;
    logic [NP-1:0][511:0]      in_data;
    logic [NP-1:0]             in_sof;
    logic [NP-1:0]             in_eof;
    logic [NP-1:0][6:0]        in_eop_len;
    logic [31:0]               frame_cnt;
    logic [15:0]               orphan_cnt;
    logic [15:0]               sof_err_cnt;

    mac_rx_if rx_if ();

    mac_rx_arb #(.NUM_PORTS(NP)) dut (
        .clk_dp      (clk_dp),
        .rst_dp_n    (rst_dp_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_eof      (in_eof),
        .in_eop_len  (in_eop_len),
        .rx          (rx_if),
        .frame_cnt   (frame_cnt),
        .orphan_cnt  (orphan_cnt),
        .sof_err_cnt (sof_err_cnt)
    );

    always #5 clk_dp = ~clk_dp;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: arbitration expressed as a plain search over ports.
    bit           m_en;
    bit           m_locked;
    int           m_lock;
    int           m_rr;
    bit           m_ov;
    logic [511:0] m_od;
    bit           m_os;
    bit           m_oe;
    logic [6:0]   m_ol;
    int           m_op;
    longint       m_fc;
    longint       m_oc;
    longint       m_sc;

    vec_t tab[$];
    vec_t none_v;

    function automatic void model_reset();
        m_en = 0; m_locked = 0; m_lock = 0; m_rr = 0;
        m_ov = 0; m_od = '0; m_os = 0; m_oe = 0; m_ol = '0; m_op = 0;
        m_fc = 0; m_oc = 0; m_sc = 0;
    endfunction

    function automatic void model_eval(output logic [NP-1:0] xr, output int acc);
        bit free;
        int p;
        free = !m_ov || (rx_if.ready === 1'b1);
        xr   = '0;
        acc  = -1;
        if (m_en) begin
            if (!m_locked) begin
                for (int q = 0; q < NP; q++)
                    if (in_valid[q] && !in_sof[q]) xr[q] = 1'b1;
                if (free) begin
                    for (int k = 0; k < NP; k++) begin
                        p = (m_rr + k) % NP;
                        if (acc < 0 && in_valid[p] && in_sof[p]) acc = p;
                    end
                end
                if (acc >= 0) xr[acc] = 1'b1;
            end else if (free) begin
                xr[m_lock] = 1'b1;
                if (in_valid[m_lock]) acc = m_lock;
            end
        end
    endfunction

    function automatic void model_update(input int acc);
        bit orph;
        orph = m_en && !m_locked && ((in_valid & ~in_sof) != '0);
        if (acc >= 0) begin
            m_ov = 1; m_od = in_data[acc]; m_oe = in_eof[acc];
            m_ol = in_eop_len[acc]; m_op = acc;
            if (m_locked) begin
                m_os = 0;
                if (in_sof[acc] && m_sc < 65535) m_sc++;
                if (in_eof[acc]) m_locked = 0;
            end else begin
                m_os = 1;
                m_rr = (acc + 1) % NP;
                m_lock = acc;
                m_locked = !in_eof[acc];
            end
            if (in_eof[acc] && m_fc < 64'hFFFF_FFFF) m_fc++;
        end else if (rx_if.ready) begin
            m_ov = 0;
        end
        if (orph && m_oc < 65535) m_oc++;
        m_en = 1;
    endfunction

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic vec_t mk(logic [31:0] v, logic [31:0] s, logic [31:0] e, bit rdy,
                                logic [31:0] xr, bit xv, int xp, bit xs, bit xe);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.rdy = rdy;
        t.xr = xr; t.xv = xv; t.xp = xp; t.xs = xs; t.xe = xe;
        return t;
    endfunction

    task automatic step(input logic [31:0] v, input logic [31:0] s, input logic [31:0] e,
                        input bit rdy, input bit len_pat, input bit use_tab, input vec_t tv);
        logic [NP-1:0] xr;
        int            acc;
        @(negedge clk_dp);
        in_valid = v; in_sof = s; in_eof = e; rx_if.ready = rdy;
        for (int p = 0; p < NP; p++) begin
            for (int w = 0; w < 16; w++) in_data[p][w*32 +: 32] = $urandom();
            in_eop_len[p] = len_pat ? 7'(p + 55) : 7'($urandom());
        end
        #1;
        model_eval(xr, acc);
        chk("in_ready", in_ready, xr);
        if (m_ov) begin
            chk("rx_ctl", {rx_if.valid, rx_if.sof, rx_if.eof, rx_if.eop_len, rx_if.port},
                {1'b1, m_os, m_oe, m_ol, 5'(m_op)});
            chk("rx_data", rx_if.data, m_od);
        end else begin
            chk("rx_valid", rx_if.valid, 1'b0);
        end
        chk("counters", {frame_cnt, orphan_cnt, sof_err_cnt},
            {32'(m_fc), 16'(m_oc), 16'(m_sc)});
        if (use_tab) begin
            chk("tab_ready", in_ready, tv.xr);
            chk("tab_valid", rx_if.valid, tv.xv);
            if (tv.xv) begin
                chk("tab_fields", {rx_if.port, rx_if.sof, rx_if.eof, rx_if.eop_len},
                    {5'(tv.xp), tv.xs, tv.xe, 7'(tv.xp + 55)});
            end
        end
        @(posedge clk_dp);
        model_update(acc);
    endtask

    task automatic apply_reset();
        @(negedge clk_dp);
        rst_dp_n = 1'b0;
        in_valid = '1; in_sof = '1; in_eof = '0; rx_if.ready = 1'b1;
        #1;
        chk("rst_ready", in_ready, '0);
        chk("rst_rx_ctl", {rx_if.valid, rx_if.sof, rx_if.eof, rx_if.eop_len, rx_if.port}, '0);
        chk("rst_rx_data", rx_if.data, '0);
        chk("rst_counters", {frame_cnt, orphan_cnt, sof_err_cnt}, '0);
        model_reset();
        repeat (2) @(posedge clk_dp);
        #2 rst_dp_n = 1'b1;
    endtask

    initial begin
        in_valid = '0; in_sof = '0; in_eof = '0; in_data = '0; in_eop_len = '0;
        rx_if.ready = 1'b0;
        none_v = mk('0, '0, '0, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
        model_reset();

        // Directed walk: 3/7 contention, rr check, 1-cell frame, orphan,
        // repeated SOF under lock, 4-cycle backpressure on port 2.
        tab.push_back(mk(32'h88,  32'h88,  32'h0,   1, 32'h0,   0, 0, 0, 0));
        tab.push_back(mk(32'h88,  32'h88,  32'h0,   1, 32'h8,   0, 0, 0, 0));
        tab.push_back(mk(32'h88,  32'h80,  32'h0,   1, 32'h8,   1, 3, 1, 0));
        tab.push_back(mk(32'h88,  32'h80,  32'h8,   1, 32'h8,   1, 3, 0, 0));
        tab.push_back(mk(32'h80,  32'h80,  32'h0,   1, 32'h80,  1, 3, 0, 1));
        tab.push_back(mk(32'h80,  32'h0,   32'h80,  1, 32'h80,  1, 7, 1, 0));
        tab.push_back(mk(32'h180, 32'h180, 32'h180, 1, 32'h100, 1, 7, 0, 1));
        tab.push_back(mk(32'h20,  32'h20,  32'h20,  1, 32'h20,  1, 8, 1, 1));
        tab.push_back(mk(32'h200, 32'h0,   32'h0,   1, 32'h200, 1, 5, 1, 1));
        tab.push_back(mk(32'h0,   32'h0,   32'h0,   1, 32'h0,   0, 0, 0, 0));
        tab.push_back(mk(32'h2,   32'h2,   32'h0,   1, 32'h2,   0, 0, 0, 0));
        tab.push_back(mk(32'h202, 32'h2,   32'h0,   1, 32'h2,   1, 1, 1, 0));
        tab.push_back(mk(32'h6,   32'h4,   32'h2,   1, 32'h2,   1, 1, 0, 0));
        tab.push_back(mk(32'h4,   32'h4,   32'h0,   1, 32'h4,   1, 1, 0, 1));
        for (int k = 0; k < 4; k++)
            tab.push_back(mk(32'h4, 32'h0, 32'h0,   0, 32'h0,   1, 2, 1, 0));
        tab.push_back(mk(32'h4,   32'h0,   32'h0,   1, 32'h4,   1, 2, 1, 0));
        tab.push_back(mk(32'h4,   32'h0,   32'h4,   1, 32'h4,   1, 2, 0, 0));
        tab.push_back(mk(32'h0,   32'h0,   32'h0,   1, 32'h0,   1, 2, 0, 1));
        tab.push_back(mk(32'h0,   32'h0,   32'h0,   1, 32'h0,   0, 0, 0, 0));

        apply_reset();
        foreach (tab[i]) step(tab[i].v, tab[i].s, tab[i].e, tab[i].rdy, 1'b1, 1'b1, tab[i]);
        #1;
        chk("tab_final_counters", {frame_cnt, orphan_cnt, sof_err_cnt}, {32'd6, 16'd1, 16'd1});

        for (int c = 0; c < 1500; c++) begin
            step($urandom() & 32'hC000_0027, $urandom(), $urandom() & $urandom(),
                 ($urandom_range(0, 3) != 0), 1'b0, 1'b0, none_v);
        end

        // Reset while the second cell of a 4-cell port 6 frame sits on rx.
        apply_reset();
        step(32'h40, 32'h40, 32'h0, 1, 1'b1, 1'b0, none_v);
        step(32'h40, 32'h40, 32'h0, 1, 1'b1, 1'b0, none_v);
        step(32'h40, 32'h0,  32'h0, 1, 1'b1, 1'b0, none_v);
        #1;
        chk("pre_reset_valid", {rx_if.valid, rx_if.port, rx_if.sof}, {1'b1, 5'd6, 1'b0});
        apply_reset();
        step(32'h840, 32'h800, 32'h800, 1, 1'b1, 1'b1,
             mk(32'h840, 32'h800, 32'h800, 1, 32'h0,   0, 0,  0, 0));
        step(32'h840, 32'h800, 32'h800, 1, 1'b1, 1'b1,
             mk(32'h840, 32'h800, 32'h800, 1, 32'h840, 0, 0,  0, 0));
        step(32'h0,   32'h0,   32'h0,   1, 1'b1, 1'b1,
             mk(32'h0,   32'h0,   32'h0,   1, 32'h0,   1, 11, 1, 1));
        step(32'h0,   32'h0,   32'h0,   1, 1'b1, 1'b0, none_v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mac_rx_arb
`default_nettype wire
